// File: rtl/counter_timer.sv
// Up/down event timer with prescaler, wrap/stop-at-terminal and pause.
// Optional load port: define COUNTER_TIMER_LOAD_EN.
//
// Ports:
//   clk, reset (async, active-high)
//   en         count enable (freezes count and prescaler when low)
//   go         synchronous (re)start, samples dir
//   dir        0 = up (0 -> MAXCOUNT), 1 = down (MAXCOUNT -> 0)
//   pause      level hold in RUN/HOLD
//   load, load_value  (COUNTER_TIMER_LOAD_EN only) clamped count load
//   count      current count
//   running    1 in RUN
//   done       1 in DONE
//   wrap_pulse 1-cycle strobe on rollover (WRAP=1)
module counter_timer #(
  parameter int WIDTH    = 14,
  parameter int MAXCOUNT = 12348,
  parameter int PRESCALE = 1,
  parameter int WRAP     = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             go,
  input  logic             dir,
  input  logic             pause,
`ifdef COUNTER_TIMER_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
`endif
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done,
  output logic             wrap_pulse
);

  localparam int PW =
    (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LP_PLAST =
    PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] LP_MAX =
    WIDTH'(MAXCOUNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_count, w_count;
  logic [PW-1:0]    r_psc, w_psc;
  logic             r_dir, w_dir;
  logic             r_wrap, w_wrap;
  logic             r_running, r_done;

  logic [WIDTH-1:0] w_term, w_start, w_stepped;

  assign w_term    = r_dir ? '0 : LP_MAX;
  assign w_start   = r_dir ? LP_MAX : '0;
  assign w_stepped = r_dir ? r_count - WIDTH'(1)
                           : r_count + WIDTH'(1);

`ifdef COUNTER_TIMER_LOAD_EN
  logic [WIDTH-1:0] w_load;
  assign w_load =
    (load_value > LP_MAX) ? LP_MAX : load_value;
`endif

  always_comb begin
    w_next  = r_state;
    w_count = r_count;
    w_psc   = r_psc;
    w_dir   = r_dir;
    w_wrap  = 1'b0;
    if (go) begin
      w_dir   = dir;
      w_count = dir ? LP_MAX : '0;
      w_psc   = '0;
      w_next  = S_RUN;
    end
`ifdef COUNTER_TIMER_LOAD_EN
    else if (load) begin
      w_count = w_load;
      w_psc   = '0;
      if (r_state == S_DONE && w_load != w_term)
        w_next = S_RUN;
    end
`endif
    else begin
      unique case (r_state)
        S_RUN: begin
          if (pause) begin
            w_next = S_HOLD;
          end else if (en) begin
            if (r_psc == LP_PLAST) begin
              w_psc = '0;
              if (WRAP != 0) begin
                if (r_count == w_term) begin
                  w_count = w_start;
                  w_wrap  = 1'b1;
                end else begin
                  w_count = w_stepped;
                end
              end else if (r_count == w_term) begin
                // already at terminal (e.g. after a load):
                // stop rather than overflow
                w_next = S_DONE;
              end else begin
                w_count = w_stepped;
                if (w_stepped == w_term)
                  w_next = S_DONE;
              end
            end else begin
              w_psc = r_psc + PW'(1);
            end
          end
        end
        S_HOLD: begin
          if (!pause)
            w_next = S_RUN;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_psc     <= '0;
      r_dir     <= 1'b0;
      r_wrap    <= 1'b0;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_count   <= w_count;
      r_psc     <= w_psc;
      r_dir     <= w_dir;
      r_wrap    <= w_wrap;
      r_running <= (w_next == S_RUN);
      r_done    <= (w_next == S_DONE);
    end
  end

  assign count      = r_count;
  assign running    = r_running;
  assign done       = r_done;
  assign wrap_pulse = r_wrap;

endmodule

// File: tb/tb_counter_timer.sv
// Directed bench for counter_timer: three parameter sets
// (stop P=1, stop P=3 down, wrap P=1) sharing one stimulus bus.
module tb_counter_timer;

  logic clk = 1'b0;
  logic reset, en, go, dir, pause;
`ifdef COUNTER_TIMER_LOAD_EN
  logic        load;
  logic [13:0] load_value;
`endif

  logic [13:0] cA, cB, cC;
  logic rA, dA, wA, rB, dB, wB, rC, dC, wC;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_timer #(.WIDTH(14), .MAXCOUNT(5),
    .PRESCALE(1), .WRAP(0)) u_a (
    .clk(clk), .reset(reset), .en(en), .go(go),
    .dir(dir), .pause(pause),
`ifdef COUNTER_TIMER_LOAD_EN
    .load(load), .load_value(load_value),
`endif
    .count(cA), .running(rA), .done(dA),
    .wrap_pulse(wA));

  counter_timer #(.WIDTH(14), .MAXCOUNT(4),
    .PRESCALE(3), .WRAP(0)) u_b (
    .clk(clk), .reset(reset), .en(en), .go(go),
    .dir(dir), .pause(pause),
`ifdef COUNTER_TIMER_LOAD_EN
    .load(load), .load_value(load_value),
`endif
    .count(cB), .running(rB), .done(dB),
    .wrap_pulse(wB));

  counter_timer #(.WIDTH(14), .MAXCOUNT(3),
    .PRESCALE(1), .WRAP(1)) u_c (
    .clk(clk), .reset(reset), .en(en), .go(go),
    .dir(dir), .pause(pause),
`ifdef COUNTER_TIMER_LOAD_EN
    .load(load), .load_value(load_value),
`endif
    .count(cC), .running(rC), .done(dC),
    .wrap_pulse(wC));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic start(input logic d);
    dir = d;
    go  = 1'b1;
    tick();
    go  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({cA, cB, cC} !== 42'd0) begin
      errors++;
      $display("FAIL reset_count got %h/%h/%h want 0",
        cA, cB, cC);
    end
    checks++;
    if ({rA, dA, wA, rB, dB, wB, rC, dC, wC}
        !== 9'd0) begin
      errors++;
      $display("FAIL reset_flags got %b want 0",
        {rA, dA, wA, rB, dB, wB, rC, dC, wC});
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    start(1'b0);
    dir = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (cA !== 14'(k)) begin
        errors++;
        $display("FAIL basic_count c%0d got %0d want %0d",
          k, cA, k);
      end
      if (k < 5) begin
        checks++;
        if (rA !== 1'b1) begin
          errors++;
          $display("FAIL basic_run c%0d got %b want 1",
            k, rA);
        end
      end
    end
    tick();
    checks++;
    if ({dA, rA} !== 2'b10) begin
      errors++;
      $display("FAIL basic_done got d%b r%b want d1 r0",
        dA, rA);
    end
    repeat (3) tick();
    checks++;
    if (cA !== 14'd5 || dA !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold got %0d d%b want 5 d1",
        cA, dA);
    end
  endtask

  task automatic test_prescale();
    int exp;
    do_reset();
    start(1'b1);
    dir = 1'b0;
    checks++;
    if (cB !== 14'd4) begin
      errors++;
      $display("FAIL pre_start got %0d want 4", cB);
    end
    for (int s = 1; s <= 4; s++) begin
      exp = 5 - s;
      repeat (2) tick();
      checks++;
      if (cB !== 14'(exp) || dB !== 1'b0) begin
        errors++;
        $display("FAIL pre_wait s%0d got %0d d%b want %0d",
          s, cB, dB, exp);
      end
      tick();
      checks++;
      if (cB !== 14'(exp - 1)) begin
        errors++;
        $display("FAIL pre_step s%0d got %0d want %0d",
          s, cB, exp - 1);
      end
    end
    checks++;
    if (dB !== 1'b1 || rB !== 1'b0) begin
      errors++;
      $display("FAIL pre_done got d%b r%b want d1 r0",
        dB, rB);
    end
  endtask

  task automatic test_wrap();
    int seq [6] = '{1, 2, 3, 0, 1, 2};
    logic wp [6] = '{0, 0, 0, 1, 0, 0};
    do_reset();
    start(1'b0);
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (cC !== 14'(seq[k]) || wC !== wp[k]
          || rC !== 1'b1) begin
        errors++;
        $display("FAIL wrap c%0d got %0d w%b r%b want %0d w%b r1",
          k + 1, cC, wC, rC, seq[k], wp[k]);
      end
    end
  endtask

  task automatic test_pause();
    do_reset();
    start(1'b0);
    tick();
    pause = 1'b1;
    tick();
    checks++;
    if (rB !== 1'b0 || cB !== 14'd0) begin
      errors++;
      $display("FAIL pause_hold1 got r%b %0d want r0 0",
        rB, cB);
    end
    tick();
    checks++;
    if (rB !== 1'b0 || cB !== 14'd0) begin
      errors++;
      $display("FAIL pause_hold2 got r%b %0d want r0 0",
        rB, cB);
    end
    pause = 1'b0;
    tick();
    checks++;
    if (rB !== 1'b1 || cB !== 14'd0) begin
      errors++;
      $display("FAIL pause_resume got r%b %0d want r1 0",
        rB, cB);
    end
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    checks++;
    if (cB !== 14'd0) begin
      errors++;
      $display("FAIL pause_frozen got %0d want 0", cB);
    end
    tick();
    checks++;
    if (cB !== 14'd1) begin
      errors++;
      $display("FAIL pause_step got %0d want 1", cB);
    end
  endtask

  task automatic test_go_pause_done();
    do_reset();
    start(1'b0);
    repeat (6) tick();
    pause = 1'b1;
    tick();
    checks++;
    if (dA !== 1'b1 || cA !== 14'd5) begin
      errors++;
      $display("FAIL gpd_done got d%b %0d want d1 5",
        dA, cA);
    end
    start(1'b1);
    checks++;
    if (cA !== 14'd5 || rA !== 1'b1 || dA !== 1'b0) begin
      errors++;
      $display("FAIL gpd_run got %0d r%b d%b want 5 r1 d0",
        cA, rA, dA);
    end
    tick();
    checks++;
    if (cA !== 14'd5 || rA !== 1'b0 || dA !== 1'b0) begin
      errors++;
      $display("FAIL gpd_hold got %0d r%b d%b want 5 r0 d0",
        cA, rA, dA);
    end
    pause = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    start(1'b0);
    repeat (4) tick();
    checks++;
    if (cA !== 14'd4 || wC !== 1'b1) begin
      errors++;
      $display("FAIL ar_pre got %0d w%b want 4 w1", cA, wC);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (cA !== 14'd0 || rA !== 1'b0 || wC !== 1'b0
        || rC !== 1'b0 || rB !== 1'b0) begin
      errors++;
      $display("FAIL ar_clear got %0d rA%b wC%b rC%b rB%b want 0",
        cA, rA, wC, rC, rB);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

`ifdef COUNTER_TIMER_LOAD_EN
  task automatic test_load();
    do_reset();
    start(1'b0);
    tick();
    load = 1'b1;
    load_value = 14'd9999;
    tick();
    load = 1'b0;
    checks++;
    if (cA !== 14'd5 || rA !== 1'b1) begin
      errors++;
      $display("FAIL load_clamp got %0d r%b want 5 r1",
        cA, rA);
    end
    tick();
    checks++;
    if (cA !== 14'd5 || dA !== 1'b1) begin
      errors++;
      $display("FAIL load_term got %0d d%b want 5 d1",
        cA, dA);
    end
    load = 1'b1;
    load_value = 14'd2;
    tick();
    load = 1'b0;
    checks++;
    if (cA !== 14'd2 || rA !== 1'b1 || wA !== 1'b0) begin
      errors++;
      $display("FAIL load_done got %0d r%b w%b want 2 r1 w0",
        cA, rA, wA);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    go    = 1'b0;
    dir   = 1'b0;
    pause = 1'b0;
`ifdef COUNTER_TIMER_LOAD_EN
    load       = 1'b0;
    load_value = '0;
`endif
    test_reset();
    test_basic();
    test_prescale();
    test_wrap();
    test_pause();
    test_go_pause_done();
    test_async_reset();
`ifdef COUNTER_TIMER_LOAD_EN
    test_load();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
